// File: rtl/bitlogic_seq_pkg.sv
// bitlogic_seq_pkg
// Shared definitions for the sliced bitwise logic unit: opcode and FSM
// state encodings plus the legal-opcode decode used by the slice datapath.
// No ports; imported by bitlogic_slice and bitlogic_seq.
package bitlogic_seq_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_NAND = 3'b001,
        OP_NOR  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Codes above XOR are reserved and yield an all-zero slice.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/bitlogic_seq_slice.sv
// bitlogic_slice
// Combinational datapath for one SLICE-bit chunk: five gate arrays and an
// opcode mux that falls back to all zeros, plus the illegal-opcode flag.
// Ports:
//   op      [2:0]        operation code
//   a, b    [SLICE-1:0]  operand slices
//   y       [SLICE-1:0]  selected gate output
//   illegal              op is not a defined code
module bitlogic_slice
    import bitlogic_seq_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y,
    output logic             illegal
);

    logic [SLICE-1:0] and_y;
    logic [SLICE-1:0] nand_y;
    logic [SLICE-1:0] nor_y;
    logic [SLICE-1:0] or_y;
    logic [SLICE-1:0] xor_y;

    // All five gate arrays are always built; the opcode only picks one.
    always_comb begin
        and_y  = a & b;
        nand_y = ~(a & b);
        nor_y  = ~(a | b);
        or_y   = a | b;
        xor_y  = a ^ b;
    end

    // Reserved codes fall through to zeros so the result of an illegal
    // request is deterministic.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = and_y;
            OP_NAND: y = nand_y;
            OP_NOR:  y = nor_y;
            OP_OR:   y = or_y;
            OP_XOR:  y = xor_y;
            default: y = '0;
        endcase
        illegal = ~is_legal_op(op);
    end

endmodule

// File: rtl/bitlogic_seq.sv
// bitlogic_seq
// Multi-cycle bitwise logic unit: captures two WIDTH-bit operands and an
// opcode, then builds the result SLICE bits per clock through one shared
// bitlogic_slice, accumulating a zero flag on the way.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (op, a, b sampled on accept)
//   out_valid / out_ready result handshake
//   result [WIDTH-1:0]   operation result
//   zero                 result == 0
//   illegal              captured op was a reserved code
module bitlogic_seq
    import bitlogic_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_slice
        $error("bitlogic_seq: WIDTH must be a positive multiple of SLICE");
    end

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] base;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_y;
    logic             slice_illegal;

    // The counter selects which chunk of the captured operands feeds the
    // shared slice this cycle. The product never exceeds WIDTH-SLICE, so
    // truncating to IDX_W bits is safe even when SLICE == WIDTH.
    always_comb begin
        base    = IDX_W'(cnt_q) * IDX_W'(SLICE);
        slice_a = a_q[base +: SLICE];
        slice_b = b_q[base +: SLICE];
    end

    bitlogic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op      (op_q),
        .a       (slice_a),
        .b       (slice_b),
        .y       (slice_y),
        .illegal (slice_illegal)
    );

    // Next-state logic. IDLE captures the request and primes the result and
    // zero accumulator; BUSY writes one slice per cycle and leaves on the
    // last one; DONE holds everything until the consumer takes it.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d     = op;
                    a_d      = a;
                    b_d      = b;
                    result_d = '0;
                    zero_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                result_d[base +: SLICE] = slice_y;
                zero_d = zero_q & (slice_y == '0);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers. Reset discards any in-flight operation and clears
    // the visible outputs; op_q resets to AND so illegal reads low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'b000;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    // Handshake outputs come straight from the state register so neither
    // in_valid nor out_ready has a combinational path to them.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        result    = result_q;
        zero      = zero_q;
        illegal   = slice_illegal;
    end

endmodule

// File: tb/tb_bitlogic_seq.sv
// tb_bitlogic_seq
// Scoreboard bench for bitlogic_seq: requests push the model's answer into a
// queue, finished results pop and compare. A 32/8 instance carries most of
// the traffic; 8/8 and 16/4 instances cover the other configurations.
module tb_bitlogic_seq;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        illegal;
    } expect_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    logic        s8_in_valid, s8_in_ready, s8_out_valid, s8_out_ready;
    logic [2:0]  s8_op;
    logic [7:0]  s8_a, s8_b, s8_result;
    logic        s8_zero, s8_illegal;

    logic        s16_in_valid, s16_in_ready, s16_out_valid, s16_out_ready;
    logic [2:0]  s16_op;
    logic [15:0] s16_a, s16_b, s16_result;
    logic        s16_zero, s16_illegal;

    int assertCount = 0;
    int failCount   = 0;
    expect_t scoreboard[$];

    always #5 clk = ~clk;

    bitlogic_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    bitlogic_seq #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(s8_in_valid), .in_ready(s8_in_ready),
        .op(s8_op), .a(s8_a), .b(s8_b),
        .out_valid(s8_out_valid), .out_ready(s8_out_ready),
        .result(s8_result), .zero(s8_zero), .illegal(s8_illegal)
    );

    bitlogic_seq #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(s16_in_valid), .in_ready(s16_in_ready),
        .op(s16_op), .a(s16_a), .b(s16_b),
        .out_valid(s16_out_valid), .out_ready(s16_out_ready),
        .result(s16_result), .zero(s16_zero), .illegal(s16_illegal)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: the operation is bitwise, so it is computed on the
    // whole word at once rather than slice by slice.
    function automatic expect_t modelOp(input logic [2:0] opIn, input logic [31:0] aIn,
                                        input logic [31:0] bIn);
        expect_t e;
        case (opIn)
            3'b000:  e.result = aIn & bIn;
            3'b001:  e.result = ~(aIn & bIn);
            3'b010:  e.result = ~(aIn | bIn);
            3'b011:  e.result = aIn | bIn;
            3'b100:  e.result = aIn ^ bIn;
            default: e.result = 32'h0;
        endcase
        e.zero    = (e.result == 32'h0);
        e.illegal = (opIn > 3'b100);
        return e;
    endfunction

    // Drive one request from a negedge, push its expected answer, then
    // scramble the inputs right after the accept edge.
    task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn,
                                 input logic [31:0] bIn);
        int waitCycles = 0;
        while (!in_ready && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
        op       = opIn;
        a        = aIn;
        b        = bIn;
        in_valid = 1'b1;
        scoreboard.push_back(modelOp(opIn, aIn, bIn));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 3'($urandom);
        a        = $urandom;
        b        = $urandom;
    endtask

    // Wait for the result (bounded), check latency, optionally hold off the
    // consumer while poking the inputs, then compare and complete.
    task automatic collectResult(input string tag, input int holdCycles);
        int cycles = 0;
        expect_t e;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!out_valid && cycles < 50);
        checkOutput({tag, "_latency"}, 64'(cycles), 64'd4);
        if (scoreboard.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
            e = '{32'h0, 1'b0, 1'b0};
        end else begin
            e = scoreboard.pop_front();
        end
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_result"}, 64'(result), 64'(e.result));
            checkOutput({tag, "_hold_flags"}, 64'({zero, illegal}), 64'({e.zero, e.illegal}));
            checkOutput({tag, "_hold_valid_ready"}, 64'({out_valid, in_ready}), 64'b10);
            in_valid = ~in_valid;
            a        = $urandom;
            b        = $urandom;
        end
        in_valid = 1'b0;
        checkOutput({tag, "_result"}, 64'(result), 64'(e.result));
        checkOutput({tag, "_zero"}, 64'(zero), 64'(e.zero));
        checkOutput({tag, "_illegal"}, 64'(illegal), 64'(e.illegal));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_after_handshake"}, 64'({out_valid, in_ready}), 64'b01);
        @(negedge clk);
        checkOutput({tag, "_idle_stays"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        int cycles;
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; op = 3'b000; a = '0; b = '0;
        s8_in_valid = 1'b0; s8_out_ready = 1'b0; s8_op = 3'b000; s8_a = '0; s8_b = '0;
        s16_in_valid = 1'b0; s16_out_ready = 1'b0; s16_op = 3'b000; s16_a = '0; s16_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_handshake", 64'({in_ready, out_valid}), 64'b10);
        checkOutput("reset_result", 64'(result), 64'h0);
        checkOutput("reset_flags", 64'({zero, illegal}), 64'b00);

        applyStimulus(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        collectResult("and", 0);
        applyStimulus(3'b010, 32'h0, 32'h0);
        collectResult("nor_zero_ops", 0);
        applyStimulus(3'b100, 32'h1234_5678, 32'h1234_5678);
        collectResult("xor_self", 0);
        applyStimulus(3'b011, 32'h1234_0000, 32'h0000_5678);
        collectResult("backpressure", 5);

        // Reset two slices into an operation, then a normal AND.
        applyStimulus(3'b001, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        void'(scoreboard.pop_front());
        checkOutput("midbusy_reset_handshake", 64'({in_ready, out_valid}), 64'b10);
        checkOutput("midbusy_reset_result", 64'(result), 64'h0);
        checkOutput("midbusy_reset_flags", 64'({zero, illegal}), 64'b00);
        @(negedge clk);
        applyStimulus(3'b000, 32'hFFFF_0000, 32'hF0F0_F0F0);
        collectResult("and_after_reset", 0);

        applyStimulus(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        collectResult("illegal_op", 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom);
            collectResult("random", i % 2);
        end

        // Reset coinciding with in_valid must not capture anything.
        reset = 1'b1;
        in_valid = 1'b1;
        op = 3'b011; a = 32'hFFFF_FFFF; b = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_wins", 64'({in_ready, out_valid}), 64'b10);
        checkOutput("reset_wins_result", 64'(result), 64'h0);

        // 8/8: a single BUSY cycle.
        @(negedge clk);
        s8_op = 3'b011; s8_a = 8'hA5; s8_b = 8'h5A; s8_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s8_in_valid = 1'b0;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!s8_out_valid && cycles < 50);
        checkOutput("w8_latency", 64'(cycles), 64'd1);
        checkOutput("w8_result", 64'(s8_result), 64'hFF);
        checkOutput("w8_flags", 64'({s8_zero, s8_illegal}), 64'b00);
        s8_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s8_out_ready = 1'b0;
        checkOutput("w8_after_handshake", 64'({s8_out_valid, s8_in_ready}), 64'b01);

        // 16/4: four slices.
        @(negedge clk);
        s16_op = 3'b011; s16_a = 16'hA5A5; s16_b = 16'h0F0F; s16_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s16_in_valid = 1'b0;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!s16_out_valid && cycles < 50);
        checkOutput("w16_latency", 64'(cycles), 64'd4);
        checkOutput("w16_result", 64'(s16_result), 64'hAFAF);
        checkOutput("w16_flags", 64'({s16_zero, s16_illegal}), 64'b00);
        s16_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s16_out_ready = 1'b0;
        checkOutput("w16_after_handshake", 64'({s16_out_valid, s16_in_ready}), 64'b01);

        checkOutput("scoreboard_drained", 64'(scoreboard.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
